// File: rtl/dct_row_sequencer.sv
// Gathers a raster pixel stream into LANES-wide rows, issues each row to the
// row-DCT with a start/done handshake and tracks rows/blocks.

module dct_row_lane #(
  parameter int PIX_W = 8,
  parameter int CW    = 3,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [CW-1:0]    col_i,
  input  logic [PIX_W-1:0] pix_i,
  output logic [PIX_W-1:0] lane_o
);
  logic [PIX_W-1:0] lane_q;

  always_ff @(posedge clk) begin
    if (rst)                                 lane_q <= '0;
    else if (wr_en_i && col_i == CW'(IDX))   lane_q <= pix_i;
  end

  assign lane_o = lane_q;
endmodule

module dct_row_sequencer #(
  parameter int PIX_W       = 8,
  parameter int LANES       = 8,
  parameter int ROWS        = 8,
  parameter int LEVEL_SHIFT = 1,
  parameter int CNT_W       = 16,
  localparam int RW = (ROWS  > 1) ? $clog2(ROWS)  : 1,
  localparam int CW = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [PIX_W-1:0]       in_pixel,
  output logic                   in_ready,
  output logic [PIX_W*LANES-1:0] dct_row,
  output logic                   dct_start,
  input  logic                   dct_done,
  output logic [RW-1:0]          row_idx,
  output logic                   block_start,
  output logic                   block_done,
  output logic [CNT_W-1:0]       blk_count,
  output logic                   seq_err
);
  typedef enum logic [1:0] {FILL, ISSUE, WAIT} state_t;

  localparam logic [CW-1:0] LAST_COL = CW'(LANES - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
  // Flipping the MSB turns an unsigned pixel into pixel-128 in two's complement.
  localparam logic [PIX_W-1:0] SHIFT_MASK =
    (LEVEL_SHIFT != 0) ? {1'b1, {(PIX_W-1){1'b0}}} : '0;

  state_t           state_q, state_d;
  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic [CNT_W-1:0] blk_q, blk_d;
  logic             in_ready_q, start_q, bstart_q, bdone_q, err_q;
  logic [RW-1:0]    row_idx_q;
  logic             xfer, last_done;
  logic [PIX_W-1:0] pix_st;
  logic [LANES-1:0][PIX_W-1:0] lanes;

  assign xfer      = in_valid && in_ready_q && (state_q == FILL);
  assign last_done = (state_q == WAIT) && dct_done && (row_q == LAST_ROW);
  assign pix_st    = in_pixel ^ SHIFT_MASK;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    blk_d   = blk_q;
    case (state_q)
      FILL: if (xfer) begin
        if (col_q == LAST_COL) begin
          col_d   = '0;
          state_d = ISSUE;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: if (dct_done) begin
        state_d = FILL;
        if (row_q == LAST_ROW) begin
          row_d = '0;
          blk_d = blk_q + 1'b1;
        end else begin
          row_d = row_q + 1'b1;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Strobes are registered from the next state so each output lines up with
  // the state it describes without any combinational path from the inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FILL;
      col_q      <= '0;
      row_q      <= '0;
      blk_q      <= '0;
      in_ready_q <= 1'b0;
      start_q    <= 1'b0;
      row_idx_q  <= '0;
      bstart_q   <= 1'b0;
      bdone_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      blk_q      <= blk_d;
      in_ready_q <= (state_d == FILL);
      start_q    <= (state_d == ISSUE);
      if (state_d == ISSUE) row_idx_q <= row_q;
      bstart_q   <= xfer && (row_q == '0) && (col_q == '0);
      bdone_q    <= last_done;
      if (dct_done && state_q != WAIT) err_q <= 1'b1;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    dct_row_lane #(.PIX_W(PIX_W), .CW(CW), .IDX(k)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .wr_en_i (xfer),
      .col_i   (col_q),
      .pix_i   (pix_st),
      .lane_o  (lanes[k])
    );
  end

  assign dct_row     = lanes;
  assign in_ready    = in_ready_q;
  assign dct_start   = start_q;
  assign row_idx     = row_idx_q;
  assign block_start = bstart_q;
  assign block_done  = bdone_q;
  assign blk_count   = blk_q;
  assign seq_err     = err_q;
endmodule

// File: tb/tb_dct_row_sequencer.sv
// Scoreboard bench: pixels queued on acceptance, compared lane-by-lane when
// a row is issued; a DCT responder answers starts with a fixed latency.

module tb_dct_row_sequencer;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0;
  logic [7:0]  in_pixel = '0;
  logic        in_ready, dct_start, block_start, block_done, seq_err;
  logic [63:0] dct_row;
  logic [2:0]  row_idx;
  logic [15:0] blk_count;
  logic        done_auto = 1'b0, done_man = 1'b0;
  logic        dct_done;
  assign dct_done = done_auto | done_man;

  logic        in_valid1 = 1'b0, dct_done1 = 1'b0;
  logic [7:0]  in_pixel1 = '0;
  logic        in_ready1, dct_start1, block_start1, block_done1, seq_err1;
  logic [63:0] dct_row1;
  logic [2:0]  row_idx1;
  logic [15:0] blk_count1;

  dct_row_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_pixel(in_pixel),
    .in_ready(in_ready), .dct_row(dct_row), .dct_start(dct_start),
    .dct_done(dct_done), .row_idx(row_idx), .block_start(block_start),
    .block_done(block_done), .blk_count(blk_count), .seq_err(seq_err)
  );

  dct_row_sequencer #(.LEVEL_SHIFT(0)) dut_raw (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_pixel(in_pixel1),
    .in_ready(in_ready1), .dct_row(dct_row1), .dct_start(dct_start1),
    .dct_done(dct_done1), .row_idx(row_idx1), .block_start(block_start1),
    .block_done(block_done1), .blk_count(blk_count1), .seq_err(seq_err1)
  );

  int checks = 0, failures = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [7:0] exp_q[$];
  int  mon_rows = 0, n_start = 0, n_bstart = 0, n_bdone = 0;
  bit  auto_en = 1'b0;
  int  done_lat = 3;

  // Row monitor: every issue must carry the next 8 accepted pixels in order.
  initial forever begin
    @(negedge clk);
    if (rst) mon_rows = 0;
    else begin
      if (dct_start) begin
        n_start++;
        chk("row_idx", 64'(row_idx), 64'(mon_rows));
        for (int k = 0; k < 8; k++) begin
          if (exp_q.size() == 0) chk("pix_avail", 0, 1);
          else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            chk("lane", 64'(dct_row[k*8 +: 8]), 64'(e));
          end
        end
        mon_rows = (mon_rows + 1) % 8;
      end
      if (block_start) n_bstart++;
      if (block_done)  n_bdone++;
    end
  end

  initial forever begin
    @(negedge clk);
    if (auto_en && dct_start && !rst) begin
      repeat (done_lat) @(negedge clk);
      done_auto = 1'b1;
      @(negedge clk);
      done_auto = 1'b0;
    end
  end

  task automatic send_pix(input logic [7:0] p, input bit gaps);
    int n = 0;
    if (gaps) while ($urandom_range(0, 2) == 0) begin in_valid = 1'b0; @(negedge clk); end
    in_valid = 1'b1;
    in_pixel = p;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) begin chk("ready_timeout", 0, 1); in_valid = 1'b0; return; end
    exp_q.push_back(p ^ 8'h80);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 300) begin @(negedge clk); n++; end
    if (!in_ready) chk("idle_timeout", 0, 1);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_rdy"},  64'(in_ready), 0);
    chk({tag, "_row"},  dct_row, 0);
    chk({tag, "_start"}, 64'(dct_start), 0);
    chk({tag, "_ridx"}, 64'(row_idx), 0);
    chk({tag, "_bs"},   64'(block_start), 0);
    chk({tag, "_bd"},   64'(block_done), 0);
    chk({tag, "_blk"},  64'(blk_count), 0);
    chk({tag, "_err"},  64'(seq_err), 0);
  endtask

  initial begin
    logic [63:0] cap;
    int b0, s0, n;
    logic [7:0] raw_px [8] = '{8'h80, 8'h00, 8'hFF, 8'h7F, 8'h01, 8'h02, 8'h03, 8'h04};

    repeat (3) @(negedge clk);
    chk_reset_state("rst");
    rst = 1'b0;
    @(negedge clk);
    chk("rdy_after_rst", 64'(in_ready), 1);

    // First row, then a long DCT stall
    for (int i = 0; i < 8; i++) send_pix(8'(i), 1'b0);
    chk("start_after_row", 64'(dct_start), 1);
    chk("rdy_low_issue", 64'(in_ready), 0);
    chk("row0_shifted", dct_row, 64'h8786858483828180);
    cap = dct_row;
    repeat (20) @(negedge clk);
    chk("row_stable", dct_row, cap);
    chk("rdy_low_wait", 64'(in_ready), 0);
    chk("single_start", 64'(n_start), 1);
    done_man = 1'b1;
    @(negedge clk);
    done_man = 1'b0;
    chk("rdy_after_done", 64'(in_ready), 1);
    chk("bstart_first", 64'(n_bstart), 1);

    // Finish block 0, then a block of 0xFF
    auto_en = 1'b1;
    for (int i = 0; i < 56; i++) send_pix(8'(i * 7 + 3), 1'b0);
    wait_ready();
    chk("blk_after_b0", 64'(blk_count), 1);
    chk("bdone_b0", 64'(n_bdone), 1);
    b0 = n_bstart; s0 = n_start;
    send_pix(8'hFF, 1'b0);
    chk("bstart_pulse", 64'(block_start), 1);
    for (int i = 1; i < 64; i++) send_pix(8'hFF, 1'b0);
    wait_ready();
    chk("bstart_once", 64'(n_bstart - b0), 1);
    chk("starts_per_blk", 64'(n_start - s0), 8);
    chk("bdone_b1", 64'(n_bdone), 2);
    chk("blk_after_b1", 64'(blk_count), 2);

    // Two blocks with random valid gaps
    for (int i = 0; i < 128; i++) send_pix(8'($urandom_range(0, 255)), 1'b1);
    wait_ready();
    chk("blk_after_rand", 64'(blk_count), 4);
    chk("bdone_rand", 64'(n_bdone), 4);
    chk("err_clean", 64'(seq_err), 0);

    // Spurious done while filling
    done_man = 1'b1;
    @(negedge clk);
    done_man = 1'b0;
    chk("err_set", 64'(seq_err), 1);
    for (int i = 0; i < 8; i++) send_pix(8'(8'h40 + i), 1'b0);
    wait_ready();
    chk("err_sticky", 64'(seq_err), 1);
    chk("blk_unchanged", 64'(blk_count), 4);

    // Reset partway through row 3
    for (int i = 0; i < 21; i++) send_pix(8'(i + 8'h10), 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_state("midrst");
    exp_q.delete();
    rst = 1'b0;
    @(negedge clk);
    b0 = n_bstart;
    for (int i = 0; i < 8; i++) send_pix(8'(8'hA0 + i), 1'b0);
    wait_ready();
    chk("bstart_after_rst", 64'(n_bstart - b0), 1);

    // Unshifted build
    in_valid1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n = 0;
      in_pixel1 = raw_px[i];
      while (!in_ready1 && n < 50) begin @(negedge clk); n++; end
      if (!in_ready1) chk("raw_ready_timeout", 0, 1);
      @(negedge clk);
    end
    in_valid1 = 1'b0;
    n = 0;
    while (!dct_start1 && n < 50) begin @(negedge clk); n++; end
    chk("raw_start", 64'(dct_start1), 1);
    chk("raw_lane0", 64'(dct_row1[7:0]), 64'h80);
    chk("raw_lane1", 64'(dct_row1[15:8]), 64'h00);
    chk("raw_lane2", 64'(dct_row1[23:16]), 64'hFF);
    chk("raw_lane3", 64'(dct_row1[31:24]), 64'h7F);

    repeat (4) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dct_row_sequencer.md
Name: dct_row_sequencer

Overview:
- Sequences the JPEG 8x8 DCT datapath.
- Collects a raster pixel stream into 8-pixel rows, optionally level-shifts each pixel, and issues each row to the row-DCT stage with a start/done handshake.
- Counts 8 rows per block and flags block boundaries for the downstream transpose/quantiser.
- Sits between the pixel source and the DCT row lanes.

Parameters:
PIX_W, 8, pixel width in bits
LANES, 8, pixels per row (DCT lanes)
ROWS, 8, rows per block
LEVEL_SHIFT, 1, 1 = store pixel-128 as two's complement (pixel XOR MSB); 0 = store raw pixel
CNT_W, 16, width of block counter

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
in_valid  input  1  source pixel valid
in_pixel  input  PIX_W  source pixel, raster order within block
in_ready  output  1  sequencer accepts pixel this cycle
dct_row  output  PIX_W*LANES  row to DCT; lane k at bits [k*PIX_W +: PIX_W]
dct_start  output  1  one-cycle row-issue strobe
dct_done  input  1  DCT finished current row (one-cycle pulse)
row_idx  output  clog2(ROWS)  index of row on dct_row
block_start  output  1  pulse: first pixel of a block accepted
block_done  output  1  pulse: last row of block completed
blk_count  output  CNT_W  completed blocks, wraps
seq_err  output  1  sticky: dct_done seen outside WAIT

Behaviour:
- Reset values, all outputs: in_ready=0, dct_row=0, dct_start=0, row_idx=0, block_start=0, block_done=0, blk_count=0, seq_err=0. Internal col_cnt=0, row_cnt=0, state=FILL.
- Reset mid-operation discards any partial row or block. No output pulse is produced.
- States: FILL, ISSUE, WAIT.
- FILL:
  - in_ready=1 (registered; first high cycle is the cycle after rst deasserts).
  - A transfer occurs when in_valid & in_ready. The pixel (shifted if LEVEL_SHIFT) is written to lane col_cnt; col_cnt increments.
  - A transfer with col_cnt==LANES-1 sets col_cnt to 0 and moves to ISSUE. in_ready is 0 in the following cycle.
  - in_valid low stalls with no state change. No pixel is lost or duplicated.
- ISSUE:
  - dct_start=1 for exactly one cycle; row_idx=row_cnt. Next state is WAIT.
  - dct_row is updated only by FILL writes, so it is stable from ISSUE until dct_done is sampled.
- WAIT:
  - in_ready=0. Remains in WAIT indefinitely until dct_done.
  - On dct_done:
    - If row_cnt==ROWS-1: row_cnt becomes 0, blk_count increments (wraps at 2^CNT_W), and block_done=1 in the next cycle for one cycle.
    - Otherwise: row_cnt increments.
  - In both cases state returns to FILL; in_ready=1 in the next cycle.
- Minimum row period is LANES+2 cycles plus DCT latency.
- block_start: one-cycle pulse in the cycle after the transfer with row_cnt==0 and col_cnt==0.
- dct_done is sampled only in WAIT. dct_done in FILL or ISSUE (including the same cycle as dct_start) is ignored for sequencing and sets seq_err=1. seq_err clears only on rst.
- Level shift example: pixel 0x00 stores 0x80 (-128); pixel 0xFF stores 0x7F (+127); pixel 0x80 stores 0x00.
- Registered outputs only. No combinational path from in_valid or dct_done to any output.

Test Plan:
- Reset, then stream 0x00..0x07 with in_valid held high -> in_ready high for 8 cycles; dct_start one cycle later; dct_row lane0=0x80 ... lane7=0x87; row_idx=0; in_ready=0.
- In WAIT, hold dct_done low for 20 cycles -> dct_row stable, in_ready=0, no second dct_start. Pulse dct_done -> in_ready=1 next cycle, next row_idx=1.
- Full block of 64 pixels 0xFF, dct_done 3 cycles after each start:
  - block_start once, after first pixel.
  - 8 dct_start pulses with row_idx 0..7.
  - block_done once, cycle after 8th done; blk_count=1.
- Toggle in_valid randomly over 2 blocks -> pixel order in dct_row matches raster order; blk_count=2; seq_err=0.
- Pulse dct_done during FILL -> seq_err=1 and stays 1; row_cnt unchanged.
- Assert rst after 5 pixels of row 3 -> all outputs reset values next cycle. Subsequent 8 pixels issue with row_idx=0 and block_start pulses.
- LEVEL_SHIFT=0 build, pixel 0x80 -> lane value 0x80.
